// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DIV_CYCLES = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    // Divide/remainder class occupies the upper half of the opcode space.
    function automatic logic is_div(input md_op_e op);
        return op[2];
    endfunction

    // Remainder ops return the remainder instead of the quotient.
    function automatic logic is_rem(input md_op_e op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    // rs1 treated as two's complement.
    function automatic logic is_signed_a(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // rs2 treated as two's complement.
    function automatic logic is_signed_b(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// The first iteration happens on the load edge so that 'done' pulses in the cycle
// where the final quotient/remainder are already registered.
module muldiv_div_core
    import muldiv_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         flush,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

    logic [W-1:0]     quo_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic             done_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r,
                                                input logic [W-1:0] q,
                                                input logic [W-1:0] d);
        logic [W:0]   sh;
        logic [W+1:0] diff;
        sh   = {r, q[W-1]};
        diff = {1'b0, sh} - {2'b00, d};
        if (diff[W+1]) begin
            return {sh[W-1:0], q[W-2:0], 1'b0};
        end
        return {diff[W-1:0], q[W-2:0], 1'b1};
    endfunction

    // Iteration state: quotient shifts in from the dividend register, count tracks steps.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (flush) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (load) begin
            {rem_q, quo_q} <= div_step('0, dividend, divisor);
            dvs_q    <= divisor;
            cnt_q    <= CNT_W'(1);
            active_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (active_q) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                active_q <= 1'b0;
                done_q   <= 1'b1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit; stalls the D/E register while working.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    input  logic            hold,
    output logic            stall_req,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    md_state_e       state_q;
    md_op_e          op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [XLEN-1:0] result_q;
    logic            result_valid_q;
    logic            busy_q;

    md_op_e            op_in;
    logic              div_by_zero;
    logic              div_ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN-1:0]   dvd_mag;
    logic [XLEN-1:0]   dvs_mag;
    logic              div_load;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   div_res;
    logic              div_done;
    logic [XLEN-1:0]   div_quo;
    logic [XLEN-1:0]   div_rem;

    // Capture-time decode: special divide cases and operand magnitudes for the core.
    always_comb begin
        op_in       = md_op_e'(op);
        div_by_zero = (operand2 == '0);
        div_ovf     = is_signed_b(op_in) && (operand1 == {1'b1, {(XLEN-1){1'b0}}})
                      && (operand2 == '1);
        special     = is_div(op_in) && (div_by_zero || div_ovf);
        if (div_by_zero) begin
            special_res = is_rem(op_in) ? operand1 : '1;
        end else begin
            special_res = is_rem(op_in) ? '0 : operand1;
        end
        dvd_mag  = (is_signed_a(op_in) && operand1[XLEN-1]) ? -operand1 : operand1;
        dvs_mag  = (is_signed_b(op_in) && operand2[XLEN-1]) ? -operand2 : operand2;
        div_load = (state_q == ST_IDLE) && start && !flush && is_div(op_in) && !special;
    end

    // Hazard request: covers the issue cycle plus every busy compute cycle.
    always_comb begin
        stall_req = ((state_q == ST_IDLE) && start && !flush)
                    || (state_q == ST_MUL) || (state_q == ST_DIV);
    end

    // Full-width product on extended operands; low or high half selected by op.
    always_comb begin
        a_ext   = is_signed_a(op_q) ? {{XLEN{a_q[XLEN-1]}}, a_q} : {{XLEN{1'b0}}, a_q};
        b_ext   = is_signed_b(op_q) ? {{XLEN{b_q[XLEN-1]}}, b_q} : {{XLEN{1'b0}}, b_q};
        prod    = a_ext * b_ext;
        mul_res = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // Sign fixup: quotient negative on sign mismatch, remainder follows dividend.
    always_comb begin
        div_res = is_rem(op_q) ? (r_neg_q ? -div_rem : div_rem)
                               : (q_neg_q ? -div_quo : div_quo);
    end

    muldiv_div_core #(
        .W(XLEN)
    ) u_div (
        .clk      (clk),
        .nrst     (nrst),
        .flush    (flush),
        .load     (div_load),
        .dividend (dvd_mag),
        .divisor  (dvs_mag),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Control FSM with registered result, valid and busy.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= ST_IDLE;
            op_q           <= MD_MUL;
            a_q            <= '0;
            b_q            <= '0;
            q_neg_q        <= 1'b0;
            r_neg_q        <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else if (flush) begin
            state_q        <= ST_IDLE;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= op_in;
                        a_q     <= operand1;
                        b_q     <= operand2;
                        q_neg_q <= is_signed_a(op_in) && (operand1[XLEN-1] ^ operand2[XLEN-1]);
                        r_neg_q <= is_signed_a(op_in) && operand1[XLEN-1];
                        busy_q  <= 1'b1;
                        if (!is_div(op_in)) begin
                            state_q <= ST_MUL;
                        end else if (special) begin
                            state_q        <= ST_DONE;
                            result_q       <= special_res;
                            result_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    state_q        <= ST_DONE;
                    result_q       <= mul_res;
                    result_valid_q <= 1'b1;
                end
                ST_DIV: begin
                    if (div_done) begin
                        state_q        <= ST_DONE;
                        result_q       <= div_res;
                        result_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!hold) begin
                        state_q        <= ST_IDLE;
                        result_valid_q <= 1'b0;
                        busy_q         <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule
